// File: rtl/uart_rx_controller.sv
// UART receive controller: arms the receiver, queues frames in a FIFO, tracks errors.
// Define UART_RX_TIMEOUT_EN to build the idle-timeout interrupt.
module uart_rx_controller #(
    parameter int DATA_SIZE      = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx_enable,
    output logic                          rx_start_n,
    input  logic [DATA_SIZE-1:0]          rx_data_in,
    input  logic                          rx_done_in,
    input  logic                          parity_error_in,
    input  logic                          stop_error_in,
    input  logic                          break_error_in,
    output logic                          rd_valid,
    output logic [DATA_SIZE-1:0]          rd_data,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [3:0]                    err_status,
    input  logic                          err_clr,
    output logic                          irq,
    output logic                          timeout_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [3:0] {
        DISABLED = 4'b0001,
        ARMED    = 4'b0010,
        WRITE    = 4'b0100,
        FULL     = 4'b1000
    } state_e;

    state_e               state_q;
    logic                 rx_start_n_q;
    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic [3:0]           err_q;
    logic [3:0]           err_d;
    logic [3:0]           err_set;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 any_err;
    logic                 armed_done;

    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign push       = (state_q == WRITE);
    assign pop        = !empty && rd_ready;
    assign any_err    = parity_error_in | stop_error_in | break_error_in;
    assign armed_done = (state_q == ARMED) && rx_enable && rx_done_in;

    assign err_set = {(state_q == FULL) && rx_done_in,
                      armed_done && break_error_in,
                      armed_done && stop_error_in,
                      armed_done && parity_error_in};

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A set in the same cycle as err_clr survives the clear.
    assign err_d = (err_clr ? 4'b0000 : err_q) | err_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= DISABLED;
            rx_start_n_q <= 1'b1;
        end else begin
            rx_start_n_q <= 1'b1;
            unique case (state_q)
                DISABLED: begin
                    if (rx_enable) begin
                        if (full) begin
                            state_q <= FULL;
                        end else begin
                            state_q      <= ARMED;
                            rx_start_n_q <= 1'b0;
                        end
                    end
                end
                ARMED: begin
                    if (!rx_enable) begin
                        state_q <= DISABLED;
                    end else if (rx_done_in && !any_err) begin
                        state_q <= WRITE;
                    end else begin
                        rx_start_n_q <= 1'b0;
                    end
                end
                WRITE: begin
                    if (!rx_enable) begin
                        state_q <= DISABLED;
                    end else if (count_d == CW'(FIFO_DEPTH)) begin
                        state_q <= FULL;
                    end else begin
                        state_q      <= ARMED;
                        rx_start_n_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (!rx_enable) begin
                        state_q <= DISABLED;
                    end else if (!full) begin
                        state_q      <= ARMED;
                        rx_start_n_q <= 1'b0;
                    end
                end
                default: state_q <= DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data_in;
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else if (push || pop) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else if (!empty) begin
            if (tmo_cnt_q != TW'(TIMEOUT_CYCLES)) tmo_cnt_q <= tmo_cnt_q + TW'(1);
            if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) tmo_q <= 1'b1;
        end
    end

    assign timeout_irq = tmo_q;
`else
    assign timeout_irq = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    assign rx_start_n = rx_start_n_q;
    assign rd_valid   = !empty;
    assign rd_data    = empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign err_status = err_q;
    assign irq        = rd_valid | (err_q != 4'b0000) | timeout_irq;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller.
// Build with UART_RX_TIMEOUT_EN to exercise the idle timeout.
module tb_uart_rx_controller;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          clk;
    logic          reset_n;
    logic          rx_enable;
    logic          rx_start_n;
    logic [DW-1:0] rx_data_in;
    logic          rx_done_in;
    logic          parity_error_in;
    logic          stop_error_in;
    logic          break_error_in;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic [2:0]    fifo_count;
    logic [3:0]    err_status;
    logic          err_clr;
    logic          irq;
    logic          timeout_irq;

    int errors = 0;
    int checks = 0;

    uart_rx_controller #(
        .DATA_SIZE(DW),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_enable(rx_enable),
        .rx_start_n(rx_start_n),
        .rx_data_in(rx_data_in),
        .rx_done_in(rx_done_in),
        .parity_error_in(parity_error_in),
        .stop_error_in(stop_error_in),
        .break_error_in(break_error_in),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_ready(rd_ready),
        .fifo_count(fifo_count),
        .err_status(err_status),
        .err_clr(err_clr),
        .irq(irq),
        .timeout_irq(timeout_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // e = {break, stop, parity}
    task automatic frame(input logic [7:0] d, input logic [2:0] e);
        rx_data_in = d;
        rx_done_in = 1'b1;
        {break_error_in, stop_error_in, parity_error_in} = e;
        tick();
        rx_done_in = 1'b0;
        {break_error_in, stop_error_in, parity_error_in} = 3'b000;
        tick();
    endtask

    task automatic pop_one;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic clr_err;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        reset_n         = 1'b0;
        rx_enable       = 1'b0;
        rx_data_in      = '0;
        rx_done_in      = 1'b0;
        parity_error_in = 1'b0;
        stop_error_in   = 1'b0;
        break_error_in  = 1'b0;
        rd_ready        = 1'b0;
        err_clr         = 1'b0;
        #12;
        check("rst_start_n", rx_start_n, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_irq", irq, 0);
        check("rst_count", fifo_count, 0);
        check("rst_err", err_status, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_tmo", timeout_irq, 0);

        reset_n   = 1'b1;
        rx_enable = 1'b1;
        tick();
        check("armed_start_n", rx_start_n, 0);

        rx_data_in = 8'hA5;
        rx_done_in = 1'b1;
        tick();
        rx_done_in = 1'b0;
        check("write_start_n", rx_start_n, 1);
        check("write_rd_valid", rd_valid, 0);
        tick();
        check("a5_rd_valid", rd_valid, 1);
        check("a5_rd_data", rd_data, 8'hA5);
        check("a5_count", fifo_count, 1);
        check("a5_irq", irq, 1);
        check("a5_start_n", rx_start_n, 0);
        pop_one();
        check("a5_pop_count", fifo_count, 0);
        check("a5_pop_valid", rd_valid, 0);

        for (int i = 1; i <= 4; i++) frame(8'(i), 3'b000);
        check("full_count", fifo_count, 4);
        check("full_start_n", rx_start_n, 1);
        check("full_head", rd_data, 8'h01);

        frame(8'h05, 3'b000);
        check("ovr_err", err_status, 4'b1000);
        check("ovr_count", fifo_count, 4);
        check("ovr_head", rd_data, 8'h01);
        check("ovr_irq", irq, 1);
        clr_err();
        check("ovr_clr", err_status, 0);

        check("pop_head", rd_data, 8'h01);
        pop_one();
        check("pop_count", fifo_count, 3);
        check("pop_start_n_full", rx_start_n, 1);
        tick();
        check("pop_start_n_armed", rx_start_n, 0);
        for (int i = 2; i <= 4; i++) begin
            check("drain_order", rd_data, 32'(i));
            pop_one();
        end
        check("drain_count", fifo_count, 0);

        frame(8'h66, 3'b010);
        check("stop_count", fifo_count, 0);
        check("stop_err", err_status, 4'b0010);
        check("stop_start_n", rx_start_n, 0);
        clr_err();
        check("stop_clr", err_status, 0);

        rx_data_in      = 8'h77;
        rx_done_in      = 1'b1;
        parity_error_in = 1'b1;
        err_clr         = 1'b1;
        tick();
        rx_done_in      = 1'b0;
        parity_error_in = 1'b0;
        err_clr         = 1'b0;
        check("par_clr_err", err_status, 4'b0001);
        tick();
        check("par_count", fifo_count, 0);
        clr_err();

        frame(8'h88, 3'b100);
        check("brk_err", err_status, 4'b0100);
        check("brk_count", fifo_count, 0);
        clr_err();

        frame(8'h11, 3'b000);
        frame(8'h22, 3'b000);
        check("pp_pre_count", fifo_count, 2);
        rx_data_in = 8'h33;
        rx_done_in = 1'b1;
        tick();
        rx_done_in = 1'b0;
        rd_ready   = 1'b1;
        tick();
        rd_ready   = 1'b0;
        check("pp_count", fifo_count, 2);
        check("pp_head1", rd_data, 8'h22);
        pop_one();
        check("pp_head2", rd_data, 8'h33);
        pop_one();
        check("pp_empty", fifo_count, 0);

        frame(8'h99, 3'b010);
        rx_data_in = 8'h44;
        rx_done_in = 1'b1;
        tick();
        rx_done_in = 1'b0;
        reset_n    = 1'b0;
        #2;
        check("wrst_start_n", rx_start_n, 1);
        check("wrst_rd_valid", rd_valid, 0);
        check("wrst_count", fifo_count, 0);
        check("wrst_err", err_status, 0);
        check("wrst_irq", irq, 0);
        check("wrst_rd_data", rd_data, 0);
        tick();
        check("wrst_hold_count", fifo_count, 0);
        reset_n = 1'b1;
        tick();
        check("wrst_rearm", rx_start_n, 0);
        frame(8'h55, 3'b000);
        check("post_rst_data", rd_data, 8'h55);
        check("post_rst_count", fifo_count, 1);

`ifdef UART_RX_TIMEOUT_EN
        repeat (15) tick();
        check("tmo_before", timeout_irq, 0);
        tick();
        check("tmo_set", timeout_irq, 1);
        check("tmo_irq", irq, 1);
        pop_one();
        check("tmo_pop", timeout_irq, 0);
`else
        repeat (20) tick();
        check("tmo_off", timeout_irq, 0);
        pop_one();
`endif
        check("tmo_drain", fifo_count, 0);

        rx_enable = 1'b0;
        tick();
        check("dis_start_n", rx_start_n, 1);
        frame(8'hEE, 3'b001);
        check("dis_count", fifo_count, 0);
        check("dis_err", err_status, 0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("empty_pop_count", fifo_count, 0);
        check("empty_pop_valid", rd_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
